// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins toward the master plus the local
// parallel transmit/receive handshake. Optional overrun signalling is
// present only when SPI_SLAVE_OVERRUN_EN is defined.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  rx_ack;
  logic                  rx_overrun;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, busy, rx_overrun
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, busy, rx_overrun
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave, oversampled in the clk domain.
// sclk/cs_n/mosi are synchronized, edges detected against a history stage,
// MOSI is deserialized into rx_data words and a locally loaded word is
// serialized on MISO. Back-to-back words within one cs_n assertion supported.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (adds rx_ack / rx_overrun).
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  // _p0/_p1 form the synchronizer, _p2 is the edge-detect history.
  // mosi only needs the synchronizer: it is sampled from _p1 in the same
  // cycle that the sclk _p1/_p2 comparison flags a rise, so it stays aligned.
  logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic r_cs_p0,   r_cs_p1,   r_cs_p2;
  logic r_mosi_p0, r_mosi_p1;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wbound;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_done;
  logic                  r_rx_valid;
  logic                  r_miso;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_tx_ready;

  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic                  w_consume;
  logic                  w_load;
  logic                  w_complete;
  logic [DATA_WIDTH-1:0] w_reload_word;

  assign w_sclk_rise = r_sclk_p1 & ~r_sclk_p2;
  assign w_sclk_fall = ~r_sclk_p1 & r_sclk_p2;
  assign w_cs_fall   = ~r_cs_p1 & r_cs_p2;
  assign w_cs_rise   = r_cs_p1 & ~r_cs_p2;

  // Holding register moves into the shifter at frame start and at the first
  // sclk fall after a completed word; an empty holding register sends zeros.
  assign w_reload_word = r_tx_ready ? '0 : r_hold;
  assign w_consume = ((r_state == ST_IDLE) && w_cs_fall) ||
                     ((r_state == ST_ACTIVE) && !w_cs_rise && w_sclk_fall && r_wbound);
  assign w_load     = bus.tx_load && r_tx_ready && !w_consume;
  assign w_complete = (r_state == ST_ACTIVE) && !w_cs_rise && w_sclk_rise &&
                      (r_cnt == LAST_BIT);

  // Input synchronizers and history; reset to the idle line state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_p0 <= 1'b0;
      r_sclk_p1 <= 1'b0;
      r_sclk_p2 <= 1'b0;
      r_cs_p0   <= 1'b1;
      r_cs_p1   <= 1'b1;
      r_cs_p2   <= 1'b1;
      r_mosi_p0 <= 1'b0;
      r_mosi_p1 <= 1'b0;
    end else begin
      r_sclk_p0 <= bus.sclk;
      r_sclk_p1 <= r_sclk_p0;
      r_sclk_p2 <= r_sclk_p1;
      r_cs_p0   <= bus.cs_n;
      r_cs_p1   <= r_cs_p0;
      r_cs_p2   <= r_cs_p1;
      r_mosi_p0 <= bus.mosi;
      r_mosi_p1 <= r_mosi_p0;
    end
  end

  // Frame FSM: bit counting, RX deserialization, TX shifting and word completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wbound   <= 1'b0;
      r_rx_data  <= '0;
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= r_done;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_cnt      <= '0;
            r_wbound   <= 1'b0;
            r_tx_shift <= w_reload_word;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            // Partial RX word is simply abandoned.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wbound <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_p1};
            if (r_cnt == LAST_BIT) begin
              r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_p1};
              r_done    <= 1'b1;
              r_cnt     <= '0;
              r_wbound  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_wbound) begin
              r_tx_shift <= w_reload_word;
              r_wbound   <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Registered MISO: shifter MSB while a frame is active, otherwise 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso <= 1'b0;
    end else begin
      r_miso <= (r_state == ST_ACTIVE) ? r_tx_shift[DATA_WIDTH-1] : 1'b0;
    end
  end

  // Holding register full/empty flag; consumption takes priority over a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ready <= 1'b1;
    end else if (w_consume) begin
      r_tx_ready <= 1'b1;
    end else if (w_load) begin
      r_tx_ready <= 1'b0;
    end
  end

  // Holding register data capture.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_hold <= bus.tx_data;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_unacked;
  logic r_overrun;

  // Overrun tracking: a completion while the previous word is still unacked
  // is sticky; an ack arriving together with a completion covers the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_unacked <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_complete) begin
      r_unacked <= 1'b1;
      if (r_unacked && !bus.rx_ack) begin
        r_overrun <= 1'b1;
      end else if (bus.rx_ack) begin
        r_overrun <= 1'b0;
      end
    end else if (bus.rx_ack) begin
      r_unacked <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign bus.rx_overrun = r_overrun;
`endif

  assign bus.miso     = r_miso;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: reset, single word, back-to-back words,
// underrun, aborted frame, mid-frame reset, and optional overrun flag.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   vcnt  = 0;
  logic [7:0] cap [0:31];

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(8)) bus();

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Record every cycle rx_valid is high together with the word it presents.
  always @(negedge clk) begin
    if (!rst && bus.rx_valid === 1'b1) begin
      if (vcnt < 32) cap[vcnt] = bus.rx_data;
      vcnt = vcnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // Master side: n bits MSB first, sclk low/high phases of 4 clk each.
  // MISO is sampled just before each rise; rx_valid is logged during the
  // high phase of bit 7.
  task automatic spi_bits(input logic [7:0] mo, input int n,
                          output logic [7:0] mi, output logic [3:0] vp);
    mi = 8'h00;
    vp = 4'h0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = mo[7-i];
      repeat (4) @(negedge clk);
      mi[7-i] = bus.miso;
      bus.sclk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (i == 7) vp[k] = bus.rx_valid;
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [7:0] mi;
    logic [3:0] vp;
    int         v0;
    int         k;

    rst         = 1'b1;
    bus.sclk    = 1'b0;
    bus.cs_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    bus.rx_ack  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", bus.miso, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("rst_overrun", bus.rx_overrun, 0);
`endif

    // Single word: send A5, receive 3C; a load while full is ignored.
    load(8'hA5);
    chk("single_ready_low", bus.tx_ready, 0);
    load(8'h11);
    bus.cs_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("single_busy", bus.busy, 1);
    chk("single_consumed", bus.tx_ready, 1);
    chk("single_miso_lat3", bus.miso, 0);
    @(negedge clk);
    chk("single_miso_lat4", bus.miso, 1);
    v0 = vcnt;
    spi_bits(8'h3C, 8, mi, vp);
    chk("single_miso_word", mi, 8'hA5);
    chk("single_valid_lat", vp, 4'b1000);
    chk("single_rx_data", bus.rx_data, 8'h3C);
    end_frame();
    chk("single_vcnt", vcnt - v0, 1);
    chk("single_cap", cap[v0], 8'h3C);
    chk("single_idle_miso", bus.miso, 0);
    chk("single_idle_busy", bus.busy, 0);

`ifdef SPI_SLAVE_OVERRUN_EN
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    chk("ovr_clear0", bus.rx_overrun, 0);
`endif

    // Back-to-back: 81 then 7E out, 12 then 34 in.
    load(8'h81);
    bus.cs_n = 1'b0;
    k = 0;
    while (bus.tx_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_ready_wait", bus.tx_ready, 1);
    load(8'h7E);
    v0 = vcnt;
    spi_bits(8'h12, 8, mi, vp);
    chk("b2b_miso0", mi, 8'h81);
    chk("b2b_rx0", bus.rx_data, 8'h12);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ovr_first", bus.rx_overrun, 0);
`endif
    spi_bits(8'h34, 8, mi, vp);
    chk("b2b_miso1", mi, 8'h7E);
    chk("b2b_valid_lat", vp, 4'b1000);
    chk("b2b_rx1", bus.rx_data, 8'h34);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ovr_second", bus.rx_overrun, 1);
`endif
    end_frame();
    chk("b2b_vcnt", vcnt - v0, 2);
    chk("b2b_cap0", cap[v0], 8'h12);
    chk("b2b_cap1", cap[v0+1], 8'h34);
    chk("b2b_ready_end", bus.tx_ready, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    @(negedge clk);
    chk("ovr_ack_clear", bus.rx_overrun, 0);
`endif

    // Underrun: nothing loaded, zeros go out.
    bus.cs_n = 1'b0;
    v0 = vcnt;
    spi_bits(8'hFF, 8, mi, vp);
    chk("under_miso", mi, 8'h00);
    chk("under_rx", bus.rx_data, 8'hFF);
    end_frame();
    chk("under_vcnt", vcnt - v0, 1);

    // Abort after 5 bits, then a clean 5A frame.
    bus.cs_n = 1'b0;
    v0 = vcnt;
    spi_bits(8'h00, 5, mi, vp);
    end_frame();
    chk("abort_vcnt", vcnt - v0, 0);
    chk("abort_rx", bus.rx_data, 8'hFF);
    chk("abort_miso", bus.miso, 0);
    chk("abort_busy", bus.busy, 0);
    bus.cs_n = 1'b0;
    spi_bits(8'h5A, 8, mi, vp);
    chk("after_abort_rx", bus.rx_data, 8'h5A);
    end_frame();
    chk("after_abort_vcnt", vcnt - v0, 1);

    // Reset in the middle of a frame.
    load(8'hC3);
    bus.cs_n = 1'b0;
    spi_bits(8'hF0, 3, mi, vp);
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_miso", bus.miso, 0);
    chk("mrst_rx_data", bus.rx_data, 0);
    chk("mrst_rx_valid", bus.rx_valid, 0);
    chk("mrst_tx_ready", bus.tx_ready, 1);
    chk("mrst_busy", bus.busy, 0);
    repeat (6) @(negedge clk);
    chk("mrst_stay_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
